// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM: synchronises and debounces three push-buttons and drives
// the decade-counter chain. Define STOPWATCH_LAP_EN to build in the lap button and the LAP state.
module stopwatch_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned DB_WIDTH        = 17
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTN_START_STOP,
  input  logic       BTN_LAP,
  input  logic       BTN_CLEAR,
  output logic       COUNT_ENABLE,
  output logic       COUNT_CLEAR,
  output logic       LAP_HOLD,
  output logic [1:0] STATE
);

  localparam int unsigned BTN_START_IDX = 0;
  localparam int unsigned BTN_CLEAR_IDX = 1;
`ifdef STOPWATCH_LAP_EN
  localparam int unsigned BTN_LAP_IDX   = 2;
  localparam int unsigned NUM_BTN       = 3;
`else
  localparam int unsigned NUM_BTN       = 2;
`endif
  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUNNING = 2'b01,
    S_STOPPED = 2'b10,
    S_LAP     = 2'b11
  } state_e;

  logic [NUM_BTN-1:0]  btn_raw;
  logic [NUM_BTN-1:0]  sync1_q, sync2_q;
  logic [NUM_BTN-1:0]  db_q, db_d, db_prev_q;
  logic [NUM_BTN-1:0]  press_c;
  logic [DB_WIDTH-1:0] cnt_q [NUM_BTN];
  logic [DB_WIDTH-1:0] cnt_d [NUM_BTN];

  logic   start_ev, clear_ev, lap_ev;
  state_e state_q, state_d;
  logic   clear_d;
  logic   count_enable_q, count_clear_q;

`ifdef STOPWATCH_LAP_EN
  assign btn_raw = {BTN_LAP, BTN_CLEAR, BTN_START_STOP};
  assign lap_ev  = press_c[BTN_LAP_IDX];
`else
  logic unused_lap;
  assign unused_lap = BTN_LAP;
  assign btn_raw    = {BTN_CLEAR, BTN_START_STOP};
  assign lap_ev     = 1'b0;
`endif

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] >= DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DB_WIDTH'(1);
        end
      end
    end
  end

  assign press_c  = db_q & ~db_prev_q;
  assign start_ev = press_c[BTN_START_IDX];
  assign clear_ev = press_c[BTN_CLEAR_IDX];

  // Per-state event priority: clear > start > lap, invalid events dropped.
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear_ev) begin
          clear_d = 1'b1;
        end else if (start_ev) begin
          state_d = S_RUNNING;
        end
      end
      S_RUNNING: begin
        if (start_ev) begin
          state_d = S_STOPPED;
        end else if (lap_ev) begin
          state_d = S_LAP;
        end
      end
      S_LAP: begin
        if (start_ev) begin
          state_d = S_STOPPED;
        end else if (lap_ev) begin
          state_d = S_RUNNING;
        end
      end
      S_STOPPED: begin
        if (clear_ev) begin
          state_d = S_IDLE;
          clear_d = 1'b1;
        end else if (start_ev) begin
          state_d = S_RUNNING;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      db_q           <= '0;
      db_prev_q      <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
      state_q        <= S_IDLE;
      count_enable_q <= 1'b0;
      count_clear_q  <= 1'b0;
    end else begin
      sync1_q        <= btn_raw;
      sync2_q        <= sync1_q;
      db_q           <= db_d;
      db_prev_q      <= db_q;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
      state_q        <= state_d;
      count_enable_q <= (state_d == S_RUNNING) || (state_d == S_LAP);
      count_clear_q  <= clear_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic lap_hold_q;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) lap_hold_q <= 1'b0;
    else        lap_hold_q <= (state_d == S_LAP);
  end
  assign LAP_HOLD = lap_hold_q;
`else
  assign LAP_HOLD = 1'b0;
`endif

  assign STATE        = state_q;
  assign COUNT_ENABLE = count_enable_q;
  assign COUNT_CLEAR  = count_clear_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller with a short debounce window.
module tb_stopwatch_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_start, btn_lap, btn_clear;
  logic       count_enable, count_clear, lap_hold;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

`ifdef STOPWATCH_LAP_EN
  localparam logic [1:0] EXP_LAP_STATE = 2'b11;
  localparam logic       EXP_LAP_HOLD  = 1'b1;
`else
  localparam logic [1:0] EXP_LAP_STATE = 2'b01;
  localparam logic       EXP_LAP_HOLD  = 1'b0;
`endif

  stopwatch_controller #(
    .DEBOUNCE_CYCLES(4),
    .DB_WIDTH       (3)
  ) dut (
    .CLK           (clk),
    .RESET         (rst_n),
    .BTN_START_STOP(btn_start),
    .BTN_LAP       (btn_lap),
    .BTN_CLEAR     (btn_clear),
    .COUNT_ENABLE  (count_enable),
    .COUNT_CLEAR   (count_clear),
    .LAP_HOLD      (lap_hold),
    .STATE         (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;
    tick(2);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_en",    32'(count_enable), 32'd0);
    check_eq("rst_clr",   32'(count_clear), 32'd0);
    check_eq("rst_hold",  32'(lap_hold), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Start held 10 cycles: 2 sync + 4 debounce + 1 registered FSM.
    btn_start = 1'b1;
    tick(6);
    check_eq("start_early", 32'(state), 32'd0);
    tick(1);
    check_eq("start_state", 32'(state), 32'd1);
    check_eq("start_en",    32'(count_enable), 32'd1);
    check_eq("start_hold",  32'(lap_hold), 32'd0);
    tick(3);
    btn_start = 1'b0;
    tick(12);
    check_eq("release_state", 32'(state), 32'd1);
    check_eq("release_en",    32'(count_enable), 32'd1);

    // Bouncing start 1-0-1 then stable high.
    btn_start = 1'b1; tick(1);
    btn_start = 1'b0; tick(1);
    btn_start = 1'b1;
    tick(6);
    check_eq("bounce_early", 32'(state), 32'd1);
    tick(1);
    check_eq("bounce_state", 32'(state), 32'd2);
    check_eq("bounce_en",    32'(count_enable), 32'd0);
    tick(10);
    check_eq("bounce_single", 32'(state), 32'd2);
    btn_start = 1'b0;
    tick(12);

    // Clear in STOPPED.
    btn_clear = 1'b1;
    tick(6);
    check_eq("clr_early_pulse", 32'(count_clear), 32'd0);
    check_eq("clr_early_state", 32'(state), 32'd2);
    tick(1);
    check_eq("clr_pulse", 32'(count_clear), 32'd1);
    check_eq("clr_state", 32'(state), 32'd0);
    check_eq("clr_en",    32'(count_enable), 32'd0);
    tick(1);
    check_eq("clr_pulse_end", 32'(count_clear), 32'd0);
    btn_clear = 1'b0;
    tick(12);

    // Clear in IDLE also pulses.
    btn_clear = 1'b1;
    tick(7);
    check_eq("idle_clr_pulse", 32'(count_clear), 32'd1);
    check_eq("idle_clr_state", 32'(state), 32'd0);
    tick(1);
    check_eq("idle_clr_end", 32'(count_clear), 32'd0);
    btn_clear = 1'b0;
    tick(12);

    // Lap toggling from RUNNING.
    btn_start = 1'b1; tick(7);
    check_eq("run2_state", 32'(state), 32'd1);
    btn_start = 1'b0; tick(12);
    btn_lap = 1'b1; tick(7);
    check_eq("lap_state", 32'(state), 32'(EXP_LAP_STATE));
    check_eq("lap_hold",  32'(lap_hold), 32'(EXP_LAP_HOLD));
    check_eq("lap_en",    32'(count_enable), 32'd1);
    btn_lap = 1'b0; tick(12);
    btn_lap = 1'b1; tick(7);
    check_eq("unlap_state", 32'(state), 32'd1);
    check_eq("unlap_hold",  32'(lap_hold), 32'd0);
    btn_lap = 1'b0; tick(12);

    // Simultaneous clear+start in RUNNING: clear is not valid, start wins.
    btn_start = 1'b1; btn_clear = 1'b1;
    tick(7);
    check_eq("simul_run_state", 32'(state), 32'd2);
    check_eq("simul_run_clr",   32'(count_clear), 32'd0);
    tick(1);
    check_eq("simul_run_clr2",  32'(count_clear), 32'd0);
    btn_start = 1'b0; btn_clear = 1'b0;
    tick(12);

    // Simultaneous clear+start in STOPPED: clear wins.
    btn_start = 1'b1; btn_clear = 1'b1;
    tick(7);
    check_eq("simul_stop_state", 32'(state), 32'd0);
    check_eq("simul_stop_clr",   32'(count_clear), 32'd1);
    tick(1);
    check_eq("simul_stop_clr2",  32'(count_clear), 32'd0);
    check_eq("simul_stop_hold",  32'(state), 32'd0);
    btn_start = 1'b0; btn_clear = 1'b0;
    tick(12);

    // Async reset mid-cycle while in LAP.
    btn_start = 1'b1; tick(7);
    btn_start = 1'b0; tick(12);
    btn_lap = 1'b1; tick(7);
    btn_lap = 1'b0; tick(12);
    check_eq("pre_rst_state", 32'(state), 32'(EXP_LAP_STATE));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_state", 32'(state), 32'd0);
    check_eq("async_en",    32'(count_enable), 32'd0);
    check_eq("async_clr",   32'(count_clear), 32'd0);
    check_eq("async_hold",  32'(lap_hold), 32'd0);

    // Start held through reset release gives exactly one event.
    tick(1);
    btn_start = 1'b1;
    tick(3);
    check_eq("in_rst_state", 32'(state), 32'd0);
    rst_n = 1'b1;
    tick(6);
    check_eq("held_early", 32'(state), 32'd0);
    tick(1);
    check_eq("held_state", 32'(state), 32'd1);
    tick(10);
    check_eq("held_single", 32'(state), 32'd1);
    btn_start = 1'b0;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
